// File: rtl/bk_operand_recover.sv
// ---------------------------------------------------------------------------
// bk_operand_recover
//
// Inverse companion to the Brent-Kung adder. It takes a WIDTH+1 bit sum and
// the known operand `a`, then recovers the other operand as b = sum - a.
// The subtraction is digit-serial: DIGIT bits per RUN cycle, so each result
// takes N = WIDTH/DIGIT cycles. It also rebuilds the adder's interleaved
// operand bus from `a` and `b`. It flags sums that no WIDTH-bit `b` could
// have produced.
//
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   in_valid     input word valid
//   in_ready     block can accept a word (IDLE only)
//   in_sum       adder sum word (WIDTH+1 bits)
//   in_a         known operand
//   out_valid    result valid (DONE)
//   out_ready    downstream accepts the result
//   out_b        recovered operand, (sum - a) mod 2^WIDTH
//   out_inputs   interleaved bus: bit 2i = a[i], bit 2i+1 = b[i]
//   out_err      sum - a fell outside [0, 2^WIDTH-1]
//   busy         state != IDLE
// ---------------------------------------------------------------------------
module bk_operand_recover #(
  parameter int WIDTH = 12,
  parameter int DIGIT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH:0]       in_sum,
  input  logic [WIDTH-1:0]     in_a,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_b,
  output logic [2*WIDTH-1:0]   out_inputs,
  output logic                 out_err,
  output logic                 busy
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  generate
    if (WIDTH % DIGIT != 0) begin : g_bad_digit
      $error("bk_operand_recover: DIGIT must divide WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_reg, state_next;
  logic [WIDTH:0]       sum_reg, sum_next;
  logic [WIDTH-1:0]     a_reg, a_next;
  logic [WIDTH-1:0]     b_reg, b_next;
  logic                 borrow_reg, borrow_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic [WIDTH-1:0]     out_b_reg, out_b_next;
  logic [2*WIDTH-1:0]   out_inputs_reg, out_inputs_next;
  logic                 out_err_reg, out_err_next;

  // Digit datapath for the current RUN cycle
  int                   lo;
  logic [DIGIT-1:0]     s_dig, a_dig;
  logic [DIGIT:0]       d;
  logic [WIDTH-1:0]     b_run;      // b_reg with this cycle's digit merged in
  logic [2*WIDTH-1:0]   il_bus;     // interleave of a_reg and b_run

  // Interleaving uses b_run so the final digit lands in the bus on the same
  // edge that enters DONE.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_il
      assign il_bus[2*gi]   = a_reg[gi];
      assign il_bus[2*gi+1] = b_run[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      sum_reg        <= '0;
      a_reg          <= '0;
      b_reg          <= '0;
      borrow_reg     <= 1'b0;
      cnt_reg        <= '0;
      out_b_reg      <= '0;
      out_inputs_reg <= '0;
      out_err_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      sum_reg        <= sum_next;
      a_reg          <= a_next;
      b_reg          <= b_next;
      borrow_reg     <= borrow_next;
      cnt_reg        <= cnt_next;
      out_b_reg      <= out_b_next;
      out_inputs_reg <= out_inputs_next;
      out_err_reg    <= out_err_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    sum_next        = sum_reg;
    a_next          = a_reg;
    b_next          = b_reg;
    borrow_next     = borrow_reg;
    cnt_next        = cnt_reg;
    out_b_next      = out_b_reg;
    out_inputs_next = out_inputs_reg;
    out_err_next    = out_err_reg;
    in_ready        = 1'b0;
    out_valid       = 1'b0;

    lo    = int'(cnt_reg) * DIGIT;
    s_dig = sum_reg[lo +: DIGIT];
    a_dig = a_reg[lo +: DIGIT];
    // One guard bit: the top bit of d is the borrow out of this digit.
    d     = {1'b0, s_dig} - {1'b0, a_dig} - {{DIGIT{1'b0}}, borrow_reg};
    b_run = b_reg;
    b_run[lo +: DIGIT] = d[DIGIT-1:0];

    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          sum_next    = in_sum;
          a_next      = in_a;
          borrow_next = 1'b0;
          cnt_next    = '0;
          state_next  = RUN;
        end
      end
      RUN: begin
        b_next      = b_run;
        borrow_next = d[DIGIT];
        cnt_next    = cnt_reg + CNT_W'(1);
        if (cnt_reg == LAST) begin
          cnt_next        = '0;
          out_b_next      = b_run;
          out_inputs_next = il_bus;
          // Final borrow vs. sum MSB: borrow without carry-in means negative,
          // carry-in without borrow means b would need WIDTH+1 bits.
          out_err_next    = sum_reg[WIDTH] ^ d[DIGIT];
          state_next      = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy       = (state_reg != IDLE);
  assign out_b      = out_b_reg;
  assign out_inputs = out_inputs_reg;
  assign out_err    = out_err_reg;

endmodule

// File: tb/tb_bk_operand_recover.sv
// ---------------------------------------------------------------------------
// tb_bk_operand_recover
//
// Directed and random stimulus for bk_operand_recover. Expected results come
// from integer arithmetic on sum and a, not from the design.
// ---------------------------------------------------------------------------
module tb_bk_operand_recover;

  localparam int W   = 12;
  localparam int LAT = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W:0]    in_sum = '0;
  logic [W-1:0]  in_a = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_b;
  logic [2*W-1:0] out_inputs;
  logic          out_err;
  logic          busy;

  int total = 0;
  int bad   = 0;

  bk_operand_recover #(.WIDTH(W), .DIGIT(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sum     (in_sum),
    .in_a       (in_a),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_b      (out_b),
    .out_inputs (out_inputs),
    .out_err    (out_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: plain integer difference.
  function automatic logic [31:0] ref_b(input int sum, input int a);
    int diff;
    diff = sum - a;
    return 32'((diff + 8192) % 4096);
  endfunction

  function automatic logic [31:0] ref_err(input int sum, input int a);
    int diff;
    diff = sum - a;
    return (diff < 0 || diff > 4095) ? 32'd1 : 32'd0;
  endfunction

  function automatic logic [31:0] ref_bus(input int a, input int b);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < W; i++) begin
      r[2*i]   = a[i];
      r[2*i+1] = b[i];
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a word and wait for the acceptance edge.
  task automatic accept(input int sum, input int a);
    int waited;
    waited = 0;
    while (!in_ready && waited < 20) begin
      tick();
      waited++;
    end
    check("accept_ready", {31'd0, in_ready}, 32'd1);
    in_sum   = (W+1)'(sum);
    in_a     = W'(a);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("busy_after_accept", {31'd0, busy}, 32'd1);
  endtask

  // Wait for out_valid, then check latency and the result.
  task automatic collect(input int sum, input int a, input bit verbose);
    int lat;
    logic [31:0] eb;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    eb = ref_b(sum, a);
    check("latency", 32'(lat), 32'(LAT));
    check("out_b", {20'd0, out_b}, eb);
    check("out_err", {31'd0, out_err}, ref_err(sum, a));
    check("out_inputs", {8'd0, out_inputs}, ref_bus(a, int'(eb)));
    check("in_ready_done", {31'd0, in_ready}, 32'd0);
    if (verbose)
      $display("txn sum=%h a=%h -> b=%h bus=%h err=%0d lat=%0d",
               sum[12:0], a[11:0], out_b, out_inputs, out_err, lat);
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("valid_drop", {31'd0, out_valid}, 32'd0);
    check("ready_back", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic word(input int sum, input int a, input bit verbose);
    accept(sum, a);
    collect(sum, a, verbose);
    release_out();
  endtask

  initial begin
    int s, a, b;
    logic [31:0] hold_b;

    // Reset
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_b", {20'd0, out_b}, 32'd0);
    check("rst_out_inputs", {8'd0, out_inputs}, 32'd0);
    check("rst_out_err", {31'd0, out_err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);

    // Idle with in_valid low: nothing moves
    tick();
    tick();
    check("idle_busy", {31'd0, busy}, 32'd0);

    // Directed words
    word(13'h0002, 12'h001, 1'b1);
    check("dir1_bus", {8'd0, out_inputs}, 32'h000003);
    word(13'h1FFE, 12'hFFF, 1'b1);
    check("dir2_bus", {8'd0, out_inputs}, 32'hFFFFFF);
    word(13'h0FFF, 12'h800, 1'b1);
    check("dir3_b", {20'd0, out_b}, 32'h7FF);
    word(13'h0005, 12'h007, 1'b1);
    check("neg_b", {20'd0, out_b}, 32'hFFE);
    check("neg_err", {31'd0, out_err}, 32'd1);
    word(13'h1000, 12'h000, 1'b1);
    check("ovf_b", {20'd0, out_b}, 32'h000);
    check("ovf_err", {31'd0, out_err}, 32'd1);

    // Backpressure with a competing input word
    accept(13'h0123, 12'h045);
    collect(13'h0123, 12'h045, 1'b1);
    hold_b   = ref_b(13'h0123, 12'h045);
    in_sum   = 13'h0ABC;
    in_a     = 12'h0AB;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      check("bp_ready", {31'd0, in_ready}, 32'd0);
      check("bp_b", {20'd0, out_b}, hold_b);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_release_ready", {31'd0, in_ready}, 32'd1);
    check("bp_release_busy", {31'd0, busy}, 32'd0);
    accept(13'h0ABC, 12'h0AB);
    collect(13'h0ABC, 12'h0AB, 1'b1);
    release_out();

    // Reset in the middle of RUN
    accept(13'h0777, 12'h111);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_b", {20'd0, out_b}, 32'd0);
    check("mid_rst_bus", {8'd0, out_inputs}, 32'd0);
    check("mid_rst_err", {31'd0, out_err}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("mid_rst_no_result", {31'd0, out_valid}, 32'd0);
    end
    word(13'h0999, 12'h321, 1'b1);

    // Random: mostly consistent sums (a+b), some arbitrary sums for err
    for (int n = 0; n < 2000; n++) begin
      a = int'($urandom_range(0, 4095));
      b = int'($urandom_range(0, 4095));
      if (n % 4 == 3) s = int'($urandom_range(0, 8191));
      else            s = a + b;
      word(s, a, 1'b0);
      if (n % 4 != 3) begin
        check("rand_b", {20'd0, out_b}, 32'(b));
        check("rand_err", {31'd0, out_err}, 32'd0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
